// File: rtl/counter_sequencer_if.sv
// Control and status bundle for counter_sequencer: commands from the master, count/status back.
interface counter_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             mode;
    logic [WIDTH-1:0] tc;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic [3:0]       wraps;
    logic [1:0]       state;

    modport master (
        output start, stop, pause, mode, tc,
        input  count, busy, done, wraps, state
    );

    modport slave (
        input  start, stop, pause, mode, tc,
        output count, busy, done, wraps, state
    );
endinterface

// File: rtl/counter_sequencer.sv
// Start/stop/pause counter with one-shot or periodic terminal count and wrap tally.
module counter_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    counter_sequencer_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] tc_q_reg, tc_q_next;
    logic             mode_q_reg, mode_q_next;
    logic [3:0]       wraps_reg, wraps_next;
    logic             done_reg, done_next;
    logic             busy_reg, busy_next;
    logic             terminal;

    // Terminal compare uses the count currently on the output, so the period is tc_q+1.
    assign terminal = (count_reg == tc_q_reg);

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        tc_q_next   = tc_q_reg;
        mode_q_next = mode_q_reg;
        wraps_next  = wraps_reg;
        done_next   = 1'b0;

        if (bus.stop) begin
            state_next = ST_IDLE;
            count_next = '0;
            wraps_next = '0;
        end else if (bus.start) begin
            state_next  = ST_RUN;
            count_next  = '0;
            wraps_next  = '0;
            tc_q_next   = bus.tc;
            mode_q_next = bus.mode;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    // Pause beats a coincident terminal; the compare is retried after resume.
                    if (bus.pause) begin
                        state_next = ST_HOLD;
                    end else if (terminal) begin
                        done_next = 1'b1;
                        if (mode_q_reg) begin
                            count_next = '0;
                            if (wraps_reg != 4'd15) begin
                                wraps_next = wraps_reg + 4'd1;
                            end
                        end else begin
                            state_next = ST_DONE;
                        end
                    end else begin
                        count_next = count_reg + COUNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (!bus.pause) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end

        busy_next = (state_next == ST_RUN) || (state_next == ST_HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            count_reg  <= '0;
            tc_q_reg   <= '0;
            mode_q_reg <= 1'b0;
            wraps_reg  <= '0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            tc_q_reg   <= tc_q_next;
            mode_q_reg <= mode_q_next;
            wraps_reg  <= wraps_next;
            done_reg   <= done_next;
            busy_reg   <= busy_next;
        end
    end

    assign bus.state = state_reg;
    assign bus.count = count_reg;
    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.wraps = wraps_reg;
endmodule
